hazard_scoreboard: RTL and testbench

//   Parametrised scoreboard hazard unit for the in-order pipeline; replaces per-stage dest compares.

---
 rtl/hazard_pkg.sv | 19 +
 rtl/sb_entry.sv | 45 ++++
 rtl/hazard_scoreboard.sv | 103 ++++++++++
 tb/tb_hazard_scoreboard.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and defaults for the register scoreboard hazard unit.
package hazard_pkg;

  localparam int unsigned DEF_REG_ADDR_W = 4;
  localparam int unsigned DEF_MAX_LAT    = 3;

  function automatic int unsigned cnt_w(input int unsigned max_lat);
    return $clog2(max_lat + 1);
  endfunction

  localparam int unsigned DEF_CNT_W = cnt_w(DEF_MAX_LAT);

  typedef logic [DEF_CNT_W-1:0] cnt_t;

  localparam cnt_t LAT_ALU = cnt_t'(1);
  localparam cnt_t LAT_MEM = cnt_t'(2);
  localparam cnt_t LAT_MUL = cnt_t'(3);

endpackage

// File: rtl/sb_entry.sv
// One scoreboard slot: a pending-writeback countdown with a registered busy flag.
module sb_entry #(
  parameter int unsigned CntW = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            clear_i,
  input  logic            en_i,
  input  logic            load_i,
  input  logic [CntW-1:0] load_val_i,
  output logic [CntW-1:0] cnt_o,
  output logic            busy_o
);

  logic [CntW-1:0] cnt_d, cnt_q;
  logic            busy_d, busy_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      if (load_i) begin
        cnt_d = load_val_i;
      end else if (cnt_q != '0) begin
        cnt_d = cnt_q - CntW'(1);
      end
    end
    busy_d = (cnt_d != '0);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign busy_o = busy_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// Scoreboard hazard unit beside ID: stalls issue on RAW/WAW against in-flight writes.
// Optional bypass awareness is enabled with the HAZARD_FWD_EN macro.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int unsigned REG_ADDR_W  = DEF_REG_ADDR_W,
  parameter int unsigned MAX_LAT     = DEF_MAX_LAT,
  parameter int unsigned STALL_CNT_W = 16,
  localparam int unsigned NUM_REGS   = 2 ** REG_ADDR_W,
  localparam int unsigned CNT_W      = cnt_w(MAX_LAT)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   advance,
  input  logic                   issue_valid,
  input  logic                   two_src,
  input  logic [REG_ADDR_W-1:0]  src1,
  input  logic [REG_ADDR_W-1:0]  src2,
  input  logic [REG_ADDR_W-1:0]  dest,
  input  logic                   wb_en,
  input  logic [CNT_W-1:0]       lat,
  output logic                   hazard_output,
  output logic                   fwd1,
  output logic                   fwd2,
  output logic [NUM_REGS-1:0]    busy_vec,
  output logic [STALL_CNT_W-1:0] stall_count
);

  logic [CNT_W-1:0]       cnt [NUM_REGS];
  logic [CNT_W-1:0]       lat_eff;
  logic [NUM_REGS-1:0]    load;
  logic                   pend1, pend2, waw, accept;
  logic [STALL_CNT_W-1:0] stall_count_d, stall_count_q;

  always_comb begin
    lat_eff = lat;
    if (lat == '0) begin
      lat_eff = CNT_W'(1);
    end else if (lat > CNT_W'(MAX_LAT)) begin
      lat_eff = CNT_W'(MAX_LAT);
    end
  end

  always_comb begin
`ifdef HAZARD_FWD_EN
    // A result due next cycle is bypassed rather than stalled on.
    pend1 = (cnt[src1] > CNT_W'(1));
    pend2 = (cnt[src2] > CNT_W'(1));
    fwd1  = issue_valid & (cnt[src1] == CNT_W'(1));
    fwd2  = issue_valid & two_src & (cnt[src2] == CNT_W'(1));
`else
    pend1 = (cnt[src1] != '0);
    pend2 = (cnt[src2] != '0);
    fwd1  = 1'b0;
    fwd2  = 1'b0;
`endif
    // WAW guard also keeps a load from ever racing a decrement on one entry.
    waw           = wb_en & (cnt[dest] != '0);
    hazard_output = issue_valid & (pend1 | (two_src & pend2) | waw);
    accept        = issue_valid & ~hazard_output & advance & ~flush;
  end

  always_comb begin
    load = '0;
    for (int unsigned r = 0; r < NUM_REGS; r++) begin
      load[r] = accept & wb_en & (dest == REG_ADDR_W'(r));
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : gen_entry
    sb_entry #(
      .CntW(CNT_W)
    ) u_entry (
      .clk_i      (clk),
      .rst_i      (rst),
      .clear_i    (flush),
      .en_i       (advance),
      .load_i     (load[g]),
      .load_val_i (lat_eff),
      .cnt_o      (cnt[g]),
      .busy_o     (busy_vec[g])
    );
  end

  always_comb begin
    stall_count_d = stall_count_q;
    if (hazard_output && (stall_count_q != '1)) begin
      stall_count_d = stall_count_q + STALL_CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_count_q <= '0;
    end else begin
      stall_count_q <= stall_count_d;
    end
  end

  assign stall_count = stall_count_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed scenarios plus randomized traffic
// against a countdown-array reference model.
module tb_hazard_scoreboard;

  localparam int NREGS     = 16;
  localparam int MAXLAT    = 3;
  localparam int STALL_MAX = 15;

  logic        clk = 1'b0;
  logic        rst, flush, advance, issue_valid, two_src, wb_en;
  logic [3:0]  src1, src2, dest;
  logic [1:0]  lat;
  logic        hazard_output, fwd1, fwd2;
  logic [15:0] busy_vec;
  logic [3:0]  stall_count;

  int checks = 0;
  int errors = 0;
  int m_cnt [NREGS];
  int m_stall;

  always #5 clk = ~clk;

  hazard_scoreboard #(
    .REG_ADDR_W  (4),
    .MAX_LAT     (3),
    .STALL_CNT_W (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .flush         (flush),
    .advance       (advance),
    .issue_valid   (issue_valid),
    .two_src       (two_src),
    .src1          (src1),
    .src2          (src2),
    .dest          (dest),
    .wb_en         (wb_en),
    .lat           (lat),
    .hazard_output (hazard_output),
    .fwd1          (fwd1),
    .fwd2          (fwd2),
    .busy_vec      (busy_vec),
    .stall_count   (stall_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_pend(input int s);
`ifdef HAZARD_FWD_EN
    return m_cnt[s] > 1;
`else
    return m_cnt[s] != 0;
`endif
  endfunction

  function automatic bit m_haz();
    return issue_valid && (m_pend(int'(src1)) || (two_src && m_pend(int'(src2))) ||
                           (wb_en && m_cnt[int'(dest)] != 0));
  endfunction

  function automatic logic [15:0] m_busy();
    logic [15:0] b;
    for (int r = 0; r < NREGS; r++) b[r] = (m_cnt[r] != 0);
    return b;
  endfunction

  task automatic compare();
    bit f1, f2;
`ifdef HAZARD_FWD_EN
    f1 = issue_valid && m_cnt[int'(src1)] == 1;
    f2 = issue_valid && two_src && m_cnt[int'(src2)] == 1;
`else
    f1 = 1'b0;
    f2 = 1'b0;
`endif
    check("hazard", 32'(hazard_output), 32'(m_haz()));
    check("fwd1", 32'(fwd1), 32'(f1));
    check("fwd2", 32'(fwd2), 32'(f2));
    check("busy_vec", 32'(busy_vec), 32'(m_busy()));
    check("stall_count", 32'(stall_count), 32'(m_stall));
  endtask

  task automatic model_tick();
    bit h;
    int l;
    h = m_haz();
    if (rst) begin
      for (int r = 0; r < NREGS; r++) m_cnt[r] = 0;
      m_stall = 0;
    end else begin
      if (h && m_stall < STALL_MAX) m_stall++;
      if (flush) begin
        for (int r = 0; r < NREGS; r++) m_cnt[r] = 0;
      end else if (advance) begin
        l = (lat == 0) ? 1 : ((int'(lat) > MAXLAT) ? MAXLAT : int'(lat));
        for (int r = 0; r < NREGS; r++) begin
          if (issue_valid && !h && wb_en && int'(dest) == r) m_cnt[r] = l;
          else if (m_cnt[r] > 0) m_cnt[r]--;
        end
      end
    end
  endtask

  task automatic drive(input bit iv, input int s1, input int s2, input bit ts, input int d,
                       input bit we, input int lt, input bit adv, input bit fl);
    issue_valid = iv;
    src1        = 4'(s1);
    src2        = 4'(s2);
    two_src     = ts;
    dest        = 4'(d);
    wb_en       = we;
    lat         = 2'(lt);
    advance     = adv;
    flush       = fl;
  endtask

  task automatic settle();
    #4;
    compare();
  endtask

  task automatic tick();
    @(posedge clk);
    model_tick();
    #1;
  endtask

  task automatic idle(input int n);
    drive(0, 0, 0, 0, 0, 0, 1, 1, 0);
    for (int i = 0; i < n; i++) begin
      settle();
      tick();
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 1, 1, 0);
    tick();
    rst = 1'b0;
  endtask

  initial begin
    logic [15:0] exp_haz;
    for (int r = 0; r < NREGS; r++) m_cnt[r] = 0;
    m_stall = 0;
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 1, 1, 0);
    @(posedge clk);
    #1;
    do_reset();

    // Reset state
    settle();
    check("rst_busy", 32'(busy_vec), 32'h0);
    check("rst_stall", 32'(stall_count), 32'h0);
    check("rst_haz", 32'(hazard_output), 32'h0);
    tick();

    // 1: RAW on reg 3 with latency 2
    drive(1, 0, 0, 0, 3, 1, 2, 1, 0);
    settle();
    check("t1_issue_haz", 32'(hazard_output), 32'h0);
    tick();
    drive(1, 3, 0, 0, 0, 0, 1, 1, 0);
    settle();
    check("t1_busy", 32'(busy_vec), 32'h0008);
    check("t1_haz_c1", 32'(hazard_output), 32'h1);
    tick();
    settle();
`ifdef HAZARD_FWD_EN
    check("t1_haz_c2", 32'(hazard_output), 32'h0);
    check("t1_fwd1_c2", 32'(fwd1), 32'h1);
`else
    check("t1_haz_c2", 32'(hazard_output), 32'h1);
    tick();
    settle();
    check("t1_haz_c3", 32'(hazard_output), 32'h0);
`endif
    tick();
    idle(3);

    // 2: src2 only matters when two_src
    drive(1, 0, 0, 0, 5, 1, 3, 1, 0);
    settle();
    tick();
    drive(1, 0, 5, 0, 0, 0, 1, 1, 0);
    settle();
    check("t2_one_src", 32'(hazard_output), 32'h0);
    tick();
    drive(1, 0, 5, 1, 0, 0, 1, 1, 0);
    settle();
    check("t2_two_src", 32'(hazard_output), 32'h1);
    tick();
    idle(3);

    // 3: WAW on reg 7 holds until its count drains
    drive(1, 0, 0, 0, 7, 1, 3, 1, 0);
    settle();
    tick();
    exp_haz = 16'b0111;
    drive(1, 0, 0, 0, 7, 1, 3, 1, 0);
    for (int i = 0; i < 4; i++) begin
      settle();
      check($sformatf("t3_waw_c%0d", i), 32'(hazard_output), 32'(exp_haz[i]));
      tick();
    end
    drive(0, 0, 0, 0, 0, 0, 1, 1, 0);
    settle();
    check("t3_reload", 32'(busy_vec), 32'h0080);
    tick();
    idle(3);

    // 4: freeze holds the counter while stalls accumulate; 20 stalls saturate a 4-bit count
    do_reset();
    drive(1, 0, 0, 0, 2, 1, 2, 1, 0);
    settle();
    tick();
    drive(1, 2, 0, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 4; i++) begin
      settle();
      check("t4_frozen_haz", 32'(hazard_output), 32'h1);
      tick();
    end
    settle();
    check("t4_stall4", 32'(stall_count), 32'h4);
    check("t4_hold", 32'(busy_vec), 32'h0004);
    for (int i = 0; i < 16; i++) begin
      tick();
      settle();
    end
    check("t4_stall_sat", 32'(stall_count), 32'hf);
    do_reset();
    settle();
    check("t4_stall_rst", 32'(stall_count), 32'h0);
    check("t4_busy_rst", 32'(busy_vec), 32'h0);
    tick();

    // 5: flush drops every pending write, including the one issuing that cycle
    drive(1, 0, 0, 0, 1, 1, 3, 1, 0);
    settle();
    tick();
    drive(1, 0, 0, 0, 4, 1, 3, 1, 0);
    settle();
    tick();
    drive(1, 0, 0, 0, 9, 1, 3, 1, 0);
    settle();
    tick();
    drive(1, 0, 0, 0, 10, 1, 3, 1, 1);
    settle();
    check("t5_pre_flush", 32'(busy_vec), 32'h0212);
    tick();
    drive(0, 0, 0, 0, 0, 0, 1, 1, 0);
    settle();
    check("t5_post_flush", 32'(busy_vec), 32'h0);
    tick();

    // Randomized traffic, biased toward a few registers to provoke hazards
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      drive($urandom_range(0, 9) < 7,
            ($urandom_range(0, 1) != 0) ? $urandom_range(0, 3) : $urandom_range(0, 15),
            ($urandom_range(0, 1) != 0) ? $urandom_range(0, 3) : $urandom_range(0, 15),
            $urandom_range(0, 1) != 0,
            ($urandom_range(0, 1) != 0) ? $urandom_range(0, 3) : $urandom_range(0, 15),
            $urandom_range(0, 3) != 0,
            $urandom_range(0, 3),
            $urandom_range(0, 99) < 85,
            $urandom_range(0, 99) < 5);
      settle();
      tick();
    end
    rst = 1'b0;
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
